// File: rtl/control_ventilacion_alarma.sv
`default_nettype none
// ============================================================================
//  Module      : control_ventilacion_alarma
//  Description : Temperature supervisor with fan-request and alarm outputs.
//                Every transition needs N_CONF consecutive confirming valid
//                samples, except the operator acknowledge, which moves
//                ESPERA_REC back to VENT at once. Release thresholds sit
//                HISTERESIS below the corresponding turn-on thresholds.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_ventilacion_alarma #(
  parameter int ANCHO         = 8,
  parameter int UMBRAL_VENT   = 28,
  parameter int UMBRAL_ALARMA = 35,
  parameter int HISTERESIS    = 2,
  parameter int N_CONF        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] Temperatura,
  input  logic             Dato_valido,
  input  logic             Reconocer,
  output logic             Ventilacion,
  output logic             Alarma,
  output logic [1:0]       Estado
);

  // State codes are fixed because Estado exposes them for debug.
  localparam logic [1:0] NORMAL     = 2'b00;
  localparam logic [1:0] VENT       = 2'b01;
  localparam logic [1:0] ALARMA     = 2'b10;
  localparam logic [1:0] ESPERA_REC = 2'b11;

  localparam int CW = $clog2(N_CONF + 1);

  // Turn-on and release thresholds, resolved at elaboration at sample width.
  // The legal parameter range keeps the release values from wrapping.
  localparam logic [ANCHO-1:0] UMB_VENT_ON  = ANCHO'(UMBRAL_VENT);
  localparam logic [ANCHO-1:0] UMB_ALAR_ON  = ANCHO'(UMBRAL_ALARMA);
  localparam logic [ANCHO-1:0] UMB_VENT_OFF = ANCHO'(UMBRAL_VENT - HISTERESIS);
  localparam logic [ANCHO-1:0] UMB_ALAR_OFF = ANCHO'(UMBRAL_ALARMA - HISTERESIS);

  localparam logic [CW-1:0] CONT_MAX  = CW'(N_CONF);
  localparam logic [CW-1:0] CONT_LAST = CW'(N_CONF - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cont_sube;
  logic [CW-1:0] cont_baja;
  logic [CW-1:0] cont_sube_nxt;
  logic [CW-1:0] cont_baja_nxt;
  logic          sube_cond;
  logic          baja_cond;
  logic          sube_conf;
  logic          baja_conf;

  // Per-state confirmation conditions on the current sample.
  always_comb begin
    sube_cond = 1'b0;
    baja_cond = 1'b0;
    case (state)
      NORMAL:     sube_cond = (Temperatura >= UMB_VENT_ON);
      VENT: begin
        sube_cond = (Temperatura >= UMB_ALAR_ON);
        baja_cond = (Temperatura <  UMB_VENT_OFF);
      end
      ALARMA:     baja_cond = (Temperatura <  UMB_ALAR_OFF);
      ESPERA_REC: sube_cond = (Temperatura >= UMB_ALAR_ON);
      default: begin
        sube_cond = 1'b0;
        baja_cond = 1'b0;
      end
    endcase
    // A confirm is the valid sample that would bring its counter to N_CONF.
    sube_conf = Dato_valido && sube_cond && (cont_sube == CONT_LAST);
    baja_conf = Dato_valido && baja_cond && (cont_baja == CONT_LAST);
  end

  // Next-state selection; a rising confirm outranks the acknowledge.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: begin
        if (sube_conf)
          state_nxt = (Temperatura >= UMB_ALAR_ON) ? ALARMA : VENT;
      end
      VENT: begin
        if (sube_conf)
          state_nxt = ALARMA;
        else if (baja_conf)
          state_nxt = NORMAL;
      end
      ALARMA: begin
        if (baja_conf)
          state_nxt = ESPERA_REC;
      end
      ESPERA_REC: begin
        if (sube_conf)
          state_nxt = ALARMA;
        else if (Reconocer)
          state_nxt = VENT;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Saturating run-length counters; they hold between strobes and restart
  // on every state change.
  always_comb begin
    cont_sube_nxt = cont_sube;
    cont_baja_nxt = cont_baja;
    if (Dato_valido) begin
      if (sube_cond)
        cont_sube_nxt = (cont_sube == CONT_MAX) ? CONT_MAX : cont_sube + CW'(1);
      else
        cont_sube_nxt = '0;
      if (baja_cond)
        cont_baja_nxt = (cont_baja == CONT_MAX) ? CONT_MAX : cont_baja + CW'(1);
      else
        cont_baja_nxt = '0;
    end
    if (state_nxt != state) begin
      cont_sube_nxt = '0;
      cont_baja_nxt = '0;
    end
  end

  // State, counters and decoded outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NORMAL;
      cont_sube   <= '0;
      cont_baja   <= '0;
      Ventilacion <= 1'b0;
      Alarma      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cont_sube   <= cont_sube_nxt;
      cont_baja   <= cont_baja_nxt;
      Ventilacion <= (state_nxt == VENT);
      Alarma      <= state_nxt[1];
    end
  end

  assign Estado = state;

endmodule
`default_nettype wire

// File: tb/tb_control_ventilacion_alarma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_ventilacion_alarma
//  Description : Scoreboard bench. The driver applies one input vector per
//                clock, updates a sample-history reference model and queues
//                the expected outputs; a monitor pops and compares after
//                every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_ventilacion_alarma;

  localparam int ANCHO = 8;
  localparam int UV    = 28;
  localparam int UA    = 35;
  localparam int HIST  = 2;
  localparam int NC    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ANCHO-1:0] Temperatura = '0;
  logic             Dato_valido = 1'b0;
  logic             Reconocer = 1'b0;
  logic             Ventilacion;
  logic             Alarma;
  logic [1:0]       Estado;

  control_ventilacion_alarma #(
    .ANCHO(ANCHO), .UMBRAL_VENT(UV), .UMBRAL_ALARMA(UA),
    .HISTERESIS(HIST), .N_CONF(NC)
  ) dut (
    .clk(clk), .reset(reset), .Temperatura(Temperatura),
    .Dato_valido(Dato_valido), .Reconocer(Reconocer),
    .Ventilacion(Ventilacion), .Alarma(Alarma), .Estado(Estado)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  // Reference model: the mode plus the valid samples seen since entering it.
  int mode = 0;          // 0 normal, 1 fan, 2 alarm, 3 awaiting acknowledge
  int hist[$];

  function automatic bit rises(int m, int t);
    if (m == 0) return t >= UV;
    if (m == 1 || m == 3) return t >= UA;
    return 1'b0;
  endfunction

  function automatic bit falls(int m, int t);
    if (m == 1) return t < UV - HIST;
    if (m == 2) return t < UA - HIST;
    return 1'b0;
  endfunction

  // True when the last NC samples in this mode all satisfy the rule.
  function automatic bit confirmed(int m, bit up);
    if (hist.size() < NC) return 1'b0;
    for (int i = 0; i < NC; i++) begin
      int t = hist[hist.size() - 1 - i];
      if (up ? !rises(m, t) : !falls(m, t)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input int t, input bit v, input bit rec, input bit rst);
    int nxt;
    bit up, dn;
    @(negedge clk);
    Temperatura = ANCHO'(t);
    Dato_valido = v;
    Reconocer   = rec;
    reset       = rst;
    if (rst) begin
      mode = 0;
      hist.delete();
    end else begin
      nxt = mode;
      if (v) begin
        hist.push_back(t);
        if (hist.size() > NC) void'(hist.pop_front());
      end
      up = v && confirmed(mode, 1'b1);
      dn = v && confirmed(mode, 1'b0);
      case (mode)
        0: if (up) nxt = (t >= UA) ? 2 : 1;
        1: if (up) nxt = 2; else if (dn) nxt = 0;
        2: if (dn) nxt = 3;
        default: if (up) nxt = 2; else if (rec) nxt = 1;
      endcase
      if (nxt != mode) begin
        mode = nxt;
        hist.delete();
      end
    end
    exp_q.push_back({2'(mode), mode == 1, mode >= 2});
  endtask

  // A valid strobe followed by an idle cycle.
  task automatic sample(input int t, input bit rec);
    step(t, 1'b1, rec, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic samples(input int t, input int n);
    for (int i = 0; i < n; i++) sample(t, 1'b0);
  endtask

  task automatic do_reset();
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({Estado, Ventilacion, Alarma} !== e) begin
          n_bad++;
          $display("FAIL vec%0d estado/vent/alarma: got %b/%b/%b expected %b/%b/%b",
                   n_vec, Estado, Ventilacion, Alarma, e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int base;
    do_reset();
    // Four samples at 30 confirm the fan; three do not.
    samples(30, 4);
    // A cold sample restarts the count.
    do_reset();
    samples(30, 2); samples(20, 1); samples(30, 3);
    // Fan -> alarm -> awaiting acknowledge -> acknowledged back to fan.
    samples(36, 4); samples(32, 4);
    sample(32, 1'b1);
    // Acknowledge ignored in alarm; coincident confirm beats acknowledge.
    samples(36, 4);
    sample(36, 1'b1);
    samples(32, 4);
    samples(35, 3);
    sample(35, 1'b1);
    // Hysteresis band holds the fan; 25 releases it.
    do_reset();
    samples(30, 4);
    for (int i = 0; i < 10; i++) begin sample(27, 1'b0); sample(26, 1'b0); end
    samples(25, 4);
    // Invalid samples are ignored.
    for (int i = 0; i < 100; i++) step(40, 1'b0, 1'b0, 1'b0);
    // Direct jump to alarm from normal, then reset while awaiting acknowledge.
    samples(40, 4); samples(30, 4);
    step(40, 1'b1, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
    // Randomized stretch with drifting temperature.
    base = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 12 == 0) base = $urandom_range(40, 20);
      step(base + $urandom_range(2, 0) - 1,
           $urandom_range(99, 0) < 60,
           $urandom_range(99, 0) < 5,
           $urandom_range(999, 0) < 8);
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_ventilacion_alarma.md
CONTROL_VENTILACION_ALARMA -- requirements
Module: control_ventilacion_alarma

Interface
REQ-001 SHALL have parameter ANCHO, default 8, width of temperature sample (unsigned).
REQ-002 SHALL have parameter UMBRAL_VENT, default 28, fan-on threshold.
REQ-003 SHALL have parameter UMBRAL_ALARMA, default 35, alarm threshold.
REQ-004 SHALL have parameter HISTERESIS, default 2, release margin below each threshold.
REQ-005 SHALL have parameter N_CONF, default 4, consecutive valid samples needed to confirm any transition.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port Temperatura  input  ANCHO  temperature sample from the sensor interface.
REQ-009 SHALL have port Dato_valido  input  1  one-cycle strobe; Temperatura is sampled only when high.
REQ-010 SHALL have port Reconocer  input  1  operator alarm-acknowledge pulse.
REQ-011 SHALL have port Ventilacion  output  1  fan request, registered; feeds the 7-segment activation stage.
REQ-012 SHALL have port Alarma  output  1  alarm indication, registered; feeds the 7-segment activation stage.
REQ-013 SHALL have port Estado  output  2  current FSM state code, for debug.

Function
REQ-014 SHALL implement FSM NORMAL=00, VENT=01, ALARMA=10, ESPERA_REC=11.
REQ-015 SHALL ignore Temperatura on cycles with Dato_valido=0; counters hold.
REQ-016 SHALL keep two counters, cont_sube and cont_baja, each saturating at N_CONF, width ceil(log2(N_CONF+1)).
REQ-017 SHALL, on each valid sample, increment a counter when its state's condition is true and clear it to 0 when false.
REQ-018 SHALL take a transition on the clock edge of the valid sample that brings its counter to N_CONF; both counters clear on every state change.
REQ-019 NORMAL: sube condition T >= UMBRAL_VENT; on confirm go ALARMA if the confirming sample is >= UMBRAL_ALARMA, else VENT; no baja condition.
REQ-020 VENT: sube condition T >= UMBRAL_ALARMA -> ALARMA; baja condition T < UMBRAL_VENT-HISTERESIS -> NORMAL.
REQ-021 ALARMA: baja condition T < UMBRAL_ALARMA-HISTERESIS -> ESPERA_REC; Reconocer ignored; no sube condition.
REQ-022 ESPERA_REC: sube condition T >= UMBRAL_ALARMA -> ALARMA; Reconocer=1 -> VENT (no confirmation needed).
REQ-023 In ESPERA_REC, if a sube confirm and Reconocer occur in the same cycle, SHALL go ALARMA.
REQ-024 Comparisons SHALL be unsigned at ANCHO bits; thresholds minus HISTERESIS computed as constants with no wrap.
REQ-025 Parameters SHALL satisfy HISTERESIS < UMBRAL_VENT < UMBRAL_ALARMA-HISTERESIS and N_CONF >= 1; other values unsupported.
REQ-026 Outputs SHALL decode registered state: Ventilacion=1 only in VENT; Alarma=1 only in ALARMA and ESPERA_REC; never both high (downstream gives Ventilacion display priority).
REQ-027 Output change SHALL be visible the cycle after the confirming clock edge (1-cycle latency from the confirming sample's edge).
REQ-028 Estado SHALL equal the state register code.

Reset
REQ-029 On reset=1 at a clock edge SHALL force NORMAL, cont_sube=cont_baja=0, Ventilacion=0, Alarma=0, Estado=00, regardless of other inputs.
REQ-030 Reset asserted mid-confirmation or in any alarm state SHALL discard progress; no acknowledge is required afterwards.

Verification
REQ-031 Reset, then 4 valid samples of 30 -> Ventilacion=1, Alarma=0, Estado=01 after 4th; 3 samples give no change.
REQ-032 In NORMAL: 30,30,20,30,30,30 (all valid) -> VENT only after 6th sample (count cleared by 20).
REQ-033 From VENT, 4 samples of 36 -> Alarma=1, Ventilacion=0, Estado=10; then 4 samples of 32 -> Estado=11, Alarma stays 1; Reconocer pulse -> Estado=01, Ventilacion=1.
REQ-034 In ALARMA, Reconocer pulse with samples of 36 -> no change; in ESPERA_REC, 4th sample of 35 coincident with Reconocer -> Estado=10.
REQ-035 Hysteresis: in VENT, samples of 27 and 26 held indefinitely -> stays VENT; 4 samples of 25 -> NORMAL, both outputs 0.
REQ-036 Samples of 40 with Dato_valido=0 for 100 cycles -> no change; reset asserted in ESPERA_REC -> all outputs 0 next cycle, Estado=00.
